// File: rtl/increment_pulse_gen_pkg.sv
// Shared types and default configuration for the increment pulse generator.
// Holds the debounce FSM state encoding and the default timing constants.
package increment_pulse_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd4;
    localparam int unsigned DEF_REPEAT_DELAY    = 32'd16;
    localparam int unsigned DEF_REPEAT_PERIOD   = 32'd8;

    localparam int CNT_W = 8;
    localparam int RPT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    // The debounced level is high in both states that follow an accepted press.
    function automatic logic is_level_state(input state_e s);
        return (s == ST_PRESSED) || (s == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/increment_pulse_gen_if.sv
// Button/pulse signal bundle between the pulse generator and its environment.
interface increment_pulse_gen_if;

    logic btn_in;
    logic en;
    logic increment;
    logic btn_level;

    modport master (
        output btn_in,
        output en,
        input  increment,
        input  btn_level
    );

    modport slave (
        input  btn_in,
        input  en,
        output increment,
        output btn_level
    );

endinterface

// File: rtl/increment_pulse_gen_sync.sv
// Two-flop synchronizer for the raw asynchronous push-button level.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Synchronizer chain, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/increment_pulse_gen.sv
// Debounced push-button to single-cycle increment pulse generator.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module increment_pulse_gen
    import increment_pulse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                  clk,
    input  logic                  reset,
    increment_pulse_gen_if.slave  bus
);

    if ((DEBOUNCE_CYCLES < 32'd2) || (DEBOUNCE_CYCLES > 32'd255) ||
        (REPEAT_DELAY < 32'd2) || (REPEAT_PERIOD < 32'd2)) begin : g_bad_cfg
        $error("increment_pulse_gen: timing parameter out of range");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = DEBOUNCE_CYCLES[CNT_W-1:0];

    logic             btn_sync_s;
    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             press_pulse_s;
    logic             rpt_pulse_s;
    logic             increment_r;
    logic             btn_level_r;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.btn_in),
        .q     (btn_sync_s)
    );

    assign cnt_inc_s = cnt_r + 8'd1;

    // FSM state and stability counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Debounce next-state logic; a press is accepted on the edge its count completes.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        press_pulse_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (btn_sync_s) begin
                    state_nxt_s = ST_PRESS_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
                cnt_nxt_s = 8'd0;
            end
            ST_PRESS_WAIT: begin
                if (!btn_sync_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 8'd0;
                end else if (cnt_inc_s == DEB_LAST) begin
                    state_nxt_s   = ST_PRESSED;
                    cnt_nxt_s     = 8'd0;
                    press_pulse_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            ST_PRESSED: begin
                if (!btn_sync_s) begin
                    state_nxt_s = ST_RELEASE_WAIT;
                end else begin
                    state_nxt_s = ST_PRESSED;
                end
                cnt_nxt_s = 8'd0;
            end
            ST_RELEASE_WAIT: begin
                if (btn_sync_s) begin
                    state_nxt_s = ST_PRESSED;
                    cnt_nxt_s   = 8'd0;
                end else if (cnt_inc_s == DEB_LAST) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [RPT_W-1:0] RPT_DELAY  = REPEAT_DELAY[RPT_W-1:0];
    localparam logic [RPT_W-1:0] RPT_PERIOD = REPEAT_PERIOD[RPT_W-1:0];

    logic [RPT_W-1:0] rpt_cnt_r;
    logic [RPT_W-1:0] rpt_cnt_nxt_s;
    logic [RPT_W-1:0] rpt_inc_s;
    logic [RPT_W-1:0] rpt_thresh_s;
    logic             rpt_run_r;
    logic             rpt_run_nxt_s;

    assign rpt_inc_s    = rpt_cnt_r + 16'd1;
    assign rpt_thresh_s = rpt_run_r ? RPT_PERIOD : RPT_DELAY;

    // Repeat timer only advances while PRESSED persists; any exit restarts the delay.
    always_comb begin
        rpt_cnt_nxt_s = rpt_cnt_r;
        rpt_run_nxt_s = rpt_run_r;
        rpt_pulse_s   = 1'b0;
        if ((state_r == ST_PRESSED) && (state_nxt_s == ST_PRESSED)) begin
            if (rpt_inc_s == rpt_thresh_s) begin
                rpt_pulse_s   = 1'b1;
                rpt_cnt_nxt_s = 16'd0;
                rpt_run_nxt_s = 1'b1;
            end else begin
                rpt_cnt_nxt_s = rpt_inc_s;
            end
        end else begin
            rpt_cnt_nxt_s = 16'd0;
            rpt_run_nxt_s = 1'b0;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_cnt_r <= 16'd0;
            rpt_run_r <= 1'b0;
        end else begin
            rpt_cnt_r <= rpt_cnt_nxt_s;
            rpt_run_r <= rpt_run_nxt_s;
        end
    end
`else
    assign rpt_pulse_s = 1'b0;
`endif

    // Registered outputs; btn_level mirrors the registered state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            increment_r <= 1'b0;
            btn_level_r <= 1'b0;
        end else begin
            increment_r <= bus.en & (press_pulse_s | rpt_pulse_s);
            btn_level_r <= is_level_state(state_nxt_s);
        end
    end

    assign bus.increment = increment_r;
    assign bus.btn_level = btn_level_r;

endmodule

// File: doc/increment_pulse_gen.md
INCREMENT_PULSE_GEN -- requirements
Module: increment_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples required to accept a level change (legal range 2..255).
REQ-002 Parameter REPEAT_DELAY, default 16, hold cycles in PRESSED before the first auto-repeat pulse (used only with AUTO_REPEAT_EN).
REQ-003 Parameter REPEAT_PERIOD, default 8, cycles between subsequent auto-repeat pulses (used only with AUTO_REPEAT_EN).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 btn_in  input  1  raw, asynchronous, bouncing push-button level.
REQ-007 en  input  1  pulse enable; when 0, increment is forced to 0 while tracking continues.
REQ-008 increment  output  1  registered single-cycle pulse; drives the increment input of the downstream counter.
REQ-009 btn_level  output  1  registered debounced button level.

Function
REQ-010 btn_in SHALL pass through a two-flop synchronizer; btn_sync denotes the second-flop output.
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, with an 8-bit stability counter cnt.
REQ-012 IDLE: btn_sync=1 -> PRESS_WAIT, cnt=0; otherwise remain.
REQ-013 PRESS_WAIT: btn_sync=0 -> IDLE (bounce rejected, no pulse); btn_sync=1 -> cnt+1; on the edge where the count reaches DEBOUNCE_CYCLES -> PRESSED.
REQ-014 On the PRESS_WAIT->PRESSED edge, increment SHALL be registered high for exactly one cycle, gated by en sampled on that edge.
REQ-015 Latency: with btn_in settled high before edge 0, increment SHALL be high from edge DEBOUNCE_CYCLES+2 to edge DEBOUNCE_CYCLES+3.
REQ-016 PRESSED: btn_sync=0 -> RELEASE_WAIT, cnt=0.
REQ-017 RELEASE_WAIT: btn_sync=1 -> PRESSED with no pulse; btn_sync=0 for DEBOUNCE_CYCLES consecutive edges -> IDLE.
REQ-018 btn_level SHALL be 1 exactly when the registered state is PRESSED or RELEASE_WAIT.
REQ-019 A press held indefinitely (no AUTO_REPEAT_EN) SHALL produce exactly one pulse.
REQ-020 increment SHALL never be high on two consecutive cycles.

Reset
REQ-021 reset low SHALL asynchronously force state=IDLE, cnt=0, synchronizer flops=0, repeat counter=0, increment=0, btn_level=0.
REQ-022 reset asserted mid-press SHALL produce no pulse; after release of reset with btn_in still high, a fresh full debounce SHALL precede the next pulse.

Configuration
REQ-023 Macro AUTO_REPEAT_EN: when defined, a repeat counter runs in PRESSED and SHALL pulse increment after REPEAT_DELAY cycles in PRESSED, then every REPEAT_PERIOD cycles, each pulse gated by en.
REQ-024 The repeat counter SHALL clear on any exit from PRESSED, including a return from RELEASE_WAIT.
REQ-025 Without AUTO_REPEAT_EN, the repeat counter and its logic SHALL be absent, and only the press pulse of REQ-014 exists.

Structure
REQ-026 Package increment_pulse_pkg SHALL hold the state enum typedef and the default DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD constants.
REQ-027 The synchronizer SHALL be a separate sub-module sync_2ff (clk, reset, d, q).

Verification
REQ-028 Clean press: btn_in 0->1 held for 40 cycles, en=1 -> exactly one increment pulse, high between edges 6 and 7; btn_level=1 from edge 6.
REQ-029 Bounce: btn_in toggles 1,0,1,0 on 1-cycle intervals, then settles at 1 -> one pulse, issued only after 4 stable samples; a 3-cycle glitch alone -> no pulse.
REQ-030 Release bounce: while PRESSED, btn_in low for 2 cycles then high -> btn_level stays 1 and no second pulse.
REQ-031 en=0 during press -> no pulse and btn_level still 1; en=1 on a later press -> pulse.
REQ-032 Reset mid-operation: reset low during PRESS_WAIT -> all outputs 0 immediately; reset released with btn_in high -> pulse exactly DEBOUNCE_CYCLES+2 edges later.
REQ-033 AUTO_REPEAT_EN defined, 60-cycle hold -> pulses at press, press+16, +24, +32, ... until release; none after btn_level falls.
